me_scan_ctrl: RTL and testbench

Sequencer for one motion-estimation PE array built from `pe_col` columns. Per macroblock it:
- loads the current block and the initial search window;
- walks the array through a serpentine (down / left / up / left …) scan of SEARCH_W × SEARCH_H candidate positions;
- drives the shared `en_spr` / `en_cpr` / `sel` controls of every column;
- tags each settled candidate with its (x, y) for the downstream SAD tree / best-match logic.

It sits between the ME top-level (start/done), the search-window fetch unit (src_valid stall) and the array.

---
 rtl/me_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_me_scan_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/me_scan_ctrl.sv
// me_scan_ctrl: load / serpentine-scan sequencer for one ME PE array.
// Drives shared column enables and mux select, tags each candidate.
module me_scan_ctrl #(
  parameter int MACRO_DIM = 16,
  parameter int SEARCH_W  = 16,
  parameter int SEARCH_H  = 16,
  parameter int XW        = $clog2(SEARCH_W),
  parameter int YW        = $clog2(SEARCH_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          src_valid,
  output logic          en_spr,
  output logic          en_cpr,
  output logic [1:0]    sel,
  output logic          busy,
  output logic          cand_valid,
  output logic [XW-1:0] cand_x,
  output logic [YW-1:0] cand_y,
  output logic          done
);

  localparam int LW = $clog2(MACRO_DIM + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_VSCAN,
    S_HSHIFT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [LW-1:0] r_load_cnt;
  logic [XW-1:0] r_col;
  logic [YW-1:0] r_row;
  logic          r_cand_valid;
  logic [XW-1:0] r_cand_x;
  logic [YW-1:0] r_cand_y;
  logic          r_done;

  logic          w_load_end;
  logic          w_col_end;
  logic          w_last_col;
  logic          w_cand;
  logic          w_fin;
  logic [XW-1:0] w_col_nx;
  logic [YW-1:0] w_row_nx;

  assign w_load_end = (r_load_cnt == LW'(MACRO_DIM - 1));
  assign w_last_col = (r_col == XW'(SEARCH_W - 1));
  // odd columns run upward, so their last shift leaves row 1
  assign w_col_end  = r_col[0] ? (r_row == YW'(1))
                               : (r_row == YW'(SEARCH_H - 2));

  always_comb begin
    w_next   = r_state;
    en_spr   = 1'b0;
    en_cpr   = 1'b0;
    sel      = 2'd3;
    w_cand   = 1'b0;
    w_fin    = 1'b0;
    w_col_nx = r_col;
    w_row_nx = r_row;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        sel    = 2'd2;
        en_spr = src_valid;
        en_cpr = src_valid;
        if (src_valid && w_load_end) begin
          w_next = S_VSCAN;
          w_cand = 1'b1;
        end
      end
      S_VSCAN: begin
        sel    = r_col[0] ? 2'd1 : 2'd0;
        en_spr = src_valid;
        if (src_valid) begin
          w_cand   = 1'b1;
          w_row_nx = r_col[0] ? r_row - YW'(1)
                              : r_row + YW'(1);
          if (w_col_end) begin
            if (w_last_col) begin
              w_next = S_IDLE;
              w_fin  = 1'b1;
            end else begin
              w_next = S_HSHIFT;
            end
          end
        end
      end
      S_HSHIFT: begin
        sel    = 2'd2;
        en_spr = src_valid;
        if (src_valid) begin
          w_cand   = 1'b1;
          w_col_nx = r_col + XW'(1);
          w_next   = S_VSCAN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_load_cnt   <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_cand_valid <= 1'b0;
      r_cand_x     <= '0;
      r_cand_y     <= '0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cand_valid <= w_cand;
      r_done       <= w_fin;
      r_col        <= w_col_nx;
      r_row        <= w_row_nx;
      if (w_cand) begin
        r_cand_x <= w_col_nx;
        r_cand_y <= w_row_nx;
      end
      if (r_state == S_IDLE && start) begin
        r_load_cnt <= '0;
        r_col      <= '0;
        r_row      <= '0;
      end else if (r_state == S_LOAD && src_valid) begin
        r_load_cnt <= r_load_cnt + LW'(1);
      end
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign cand_valid = r_cand_valid;
  assign cand_x     = r_cand_x;
  assign cand_y     = r_cand_y;
  assign done       = r_done;

endmodule

// File: tb/tb_me_scan_ctrl.sv
// tb_me_scan_ctrl: vector table on a 4/3x3 instance plus a
// scoreboard-checked default instance (stalls, reset, restart).
module tb_me_scan_ctrl;

  localparam int MD  = 16;
  localparam int W   = 16;
  localparam int H   = 16;
  localparam int TOT = MD + W * (H - 1) + (W - 1);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       b_start, b_srcv, b_spr, b_cpr, b_busy, b_cv, b_done;
  logic [1:0] b_sel;
  logic [3:0] b_x, b_y;

  logic       s_start, s_srcv, s_spr, s_cpr, s_busy, s_cv, s_done;
  logic [1:0] s_sel;
  logic [1:0] s_x, s_y;

  me_scan_ctrl u_big (
    .clk(clk), .rst_n(rst_n), .start(b_start),
    .src_valid(b_srcv), .en_spr(b_spr), .en_cpr(b_cpr),
    .sel(b_sel), .busy(b_busy), .cand_valid(b_cv),
    .cand_x(b_x), .cand_y(b_y), .done(b_done)
  );

  me_scan_ctrl #(
    .MACRO_DIM(4), .SEARCH_W(3), .SEARCH_H(3)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start),
    .src_valid(s_srcv), .en_spr(s_spr), .en_cpr(s_cpr),
    .sel(s_sel), .busy(s_busy), .cand_valid(s_cv),
    .cand_x(s_x), .cand_y(s_y), .done(s_done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       st, sv, spr, cpr;
    logic [1:0] sel;
    logic       busy, cv;
    logic [1:0] x, y;
    logic       dn;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(
    input logic st, sv, spr, cpr,
    input logic [1:0] sl,
    input logic bz, cv,
    input logic [1:0] x, y,
    input logic dn);
    vec_t v;
    v.st = st; v.sv = sv; v.spr = spr; v.cpr = cpr;
    v.sel = sl; v.busy = bz; v.cv = cv;
    v.x = x; v.y = y; v.dn = dn;
    return v;
  endfunction

  typedef struct {
    int   x, y;
    logic dn;
  } cand_t;

  cand_t q[$];
  logic  m_busy = 1'b0;
  int    m_k = 0;
  int    cyc = 0;
  int    t_start = 0;
  int    n_stall = 0;
  int    n_cpr = 0;
  int    n_cand = 0;

  function automatic int sel_of(input int k);
    int j;
    if (k < MD) return 2;
    j = k - MD;
    if (j % H == H - 1) return 2;
    return ((j / H) % 2 == 1) ? 1 : 0;
  endfunction

  task automatic step(input logic st, input logic sv);
    cand_t e;
    int    n;
    @(posedge clk);
    #1;
    b_start = st;
    b_srcv  = sv;
    @(negedge clk);
    cyc++;
    chk("en_spr", b_spr, m_busy && sv);
    chk("en_cpr", b_cpr, m_busy && sv && m_k < MD);
    chk("sel", b_sel, m_busy ? sel_of(m_k) : 3);
    chk("busy", b_busy, m_busy);
    if (b_cpr) n_cpr++;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("cand_valid", b_cv, 1);
      chk("cand_x", b_x, e.x);
      chk("cand_y", b_y, e.y);
      chk("done", b_done, e.dn);
      if (b_cv) n_cand++;
      if (e.dn) begin
        chk("done_cycle", cyc - t_start, TOT + 1 + n_stall);
        chk("cpr_cycles", n_cpr, MD);
        chk("cand_count", n_cand, W * H);
      end
    end else begin
      chk("cand_valid_idle", b_cv, 0);
      chk("done_idle", b_done, 0);
    end
    if (m_busy) begin
      if (!sv) begin
        n_stall++;
      end else begin
        if (m_k >= MD - 1) begin
          n    = m_k - MD + 1;
          e.x  = n / H;
          e.y  = (e.x % 2 == 0) ? n % H : H - 1 - n % H;
          e.dn = (m_k == TOT - 1);
          q.push_back(e);
        end
        m_k++;
        if (m_k == TOT) m_busy = 1'b0;
      end
    end else if (st) begin
      m_busy  = 1'b1;
      m_k     = 0;
      t_start = cyc;
      n_stall = 0;
      n_cpr   = 0;
      n_cand  = 0;
    end
  endtask

  task automatic chk_big_reset(input string tag);
    chk({tag, "_en_spr"}, b_spr, 0);
    chk({tag, "_en_cpr"}, b_cpr, 0);
    chk({tag, "_sel"}, b_sel, 3);
    chk({tag, "_busy"}, b_busy, 0);
    chk({tag, "_cand_valid"}, b_cv, 0);
    chk({tag, "_cand_x"}, b_x, 0);
    chk({tag, "_cand_y"}, b_y, 0);
    chk({tag, "_done"}, b_done, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    b_start = 1'b0;
    b_srcv  = 1'b0;
    s_start = 1'b0;
    s_srcv  = 1'b0;

    tbl[0]  = mk(1, 1, 0, 0, 3, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 1, 2, 1, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 1, 2, 1, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 1, 1, 2, 1, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 1, 1, 2, 1, 0, 0, 0, 0);
    tbl[5]  = mk(0, 1, 1, 0, 0, 1, 1, 0, 0, 0);
    tbl[6]  = mk(0, 1, 1, 0, 0, 1, 1, 0, 1, 0);
    tbl[7]  = mk(0, 0, 0, 0, 2, 1, 1, 0, 2, 0);
    tbl[8]  = mk(0, 1, 1, 0, 2, 1, 0, 0, 0, 0);
    tbl[9]  = mk(0, 1, 1, 0, 1, 1, 1, 1, 2, 0);
    tbl[10] = mk(1, 1, 1, 0, 1, 1, 1, 1, 1, 0);
    tbl[11] = mk(0, 1, 1, 0, 2, 1, 1, 1, 0, 0);
    tbl[12] = mk(0, 1, 1, 0, 0, 1, 1, 2, 0, 0);
    tbl[13] = mk(0, 1, 1, 0, 0, 1, 1, 2, 1, 0);
    tbl[14] = mk(0, 1, 0, 0, 3, 0, 1, 2, 2, 1);
    tbl[15] = mk(0, 0, 0, 0, 3, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    chk_big_reset("rst");
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      s_start = tbl[i].st;
      s_srcv  = tbl[i].sv;
      @(negedge clk);
      chk($sformatf("v%0d_en_spr", i), s_spr, tbl[i].spr);
      chk($sformatf("v%0d_en_cpr", i), s_cpr, tbl[i].cpr);
      chk($sformatf("v%0d_sel", i), s_sel, tbl[i].sel);
      chk($sformatf("v%0d_busy", i), s_busy, tbl[i].busy);
      chk($sformatf("v%0d_cv", i), s_cv, tbl[i].cv);
      chk($sformatf("v%0d_done", i), s_done, tbl[i].dn);
      if (tbl[i].cv || i == 0) begin
        chk($sformatf("v%0d_x", i), s_x, tbl[i].x);
        chk($sformatf("v%0d_y", i), s_y, tbl[i].y);
      end
    end
    s_start = 1'b0;
    s_srcv  = 1'b0;

    step(1, 1);
    repeat (TOT + 4) step(0, 1);

    step(1, 1);
    for (int i = 0; i < 3000 && m_busy; i++)
      step(0, 1'($urandom_range(0, 1)));
    chk("rand_timeout", m_busy, 0);
    repeat (2) step(0, 1);

    repeat (TOT + 10) step(1, 1);
    for (int i = 0; i < 400 && m_k != MD + 5 * H + 3; i++)
      step(0, 1);
    chk("col5_reached", m_k, MD + 5 * H + 3);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_big_reset("midrst");
    m_busy = 1'b0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(0, 1);

    step(1, 1);
    for (int i = 0; i < 100 && m_k != MD + H - 1; i++)
      step(0, 1);
    chk("hshift_reached", m_k, MD + H - 1);
    repeat (20) step(0, 0);
    for (int i = 0; i < 400 && m_busy; i++) step(0, 1);
    chk("stall_timeout", m_busy, 0);
    repeat (3) step(0, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
